// File: rtl/trigger_framer.sv
// Trigger framer: packs per-bunch-crossing trigger samples into fixed-length
// frames, tags each frame and queues them in a show-ahead buffer for a consumer.
module trigger_framer #(
    parameter int FRAME_BX       = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TAG_W          = 4,
    parameter int SUPPRESS_EMPTY = 0
) (
    input  logic                          clk160,
    input  logic                          rst,
    input  logic                          bx_stb,
    input  logic                          trigger,
    input  logic                          trig_clr,
    output logic [TAG_W+FRAME_BX-1:0]     enc_trig,
    output logic                          trig_valid,
    input  logic                          trig_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          overflow
);

    localparam int BXW    = $clog2(FRAME_BX);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int WORD_W = TAG_W + FRAME_BX;
    localparam logic [BXW-1:0] BX_LAST = BXW'(FRAME_BX - 1);
    localparam logic [PW:0]    FULL    = (PW + 1)'(FIFO_DEPTH);

    logic [FRAME_BX-1:0] pattern;
    logic [BXW-1:0]      bx_cnt;
    logic [TAG_W-1:0]    tag;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [WORD_W-1:0]   mem [FIFO_DEPTH];

    logic [FRAME_BX-1:0] frame_pat;
    logic                frame_done;
    logic                wr_req;
    logic                pop;
    logic                wr_ok;
    logic                drop;

    // Frame completion, write admission and pop decisions for this edge
    always_comb begin
        frame_pat  = {pattern[FRAME_BX-2:0], trigger};
        frame_done = bx_stb && (bx_cnt == BX_LAST);
        wr_req     = frame_done && !((SUPPRESS_EMPTY != 0) && (frame_pat == '0));
        pop        = trig_valid && trig_ready;
        wr_ok      = wr_req && ((fill != FULL) || pop);
        drop       = wr_req && !wr_ok;
    end

    // Show-ahead head word, forced to zero while the buffer is empty
    always_comb begin
        trig_valid = (fill != '0);
        enc_trig   = trig_valid ? mem[rd_ptr] : '0;
    end

    // Sample shifting, bx/tag counting, pointers, occupancy and sticky overflow
    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            pattern  <= '0;
            bx_cnt   <= '0;
            tag      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else if (trig_clr) begin
            pattern  <= '0;
            bx_cnt   <= '0;
            tag      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (bx_stb) begin
                pattern <= frame_pat;
                bx_cnt  <= frame_done ? '0 : bx_cnt + 1'b1;
            end
            if (frame_done) begin
                tag <= tag + 1'b1;
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Frame buffer storage; contents need no reset because fill gates the output
    always_ff @(posedge clk160) begin
        if (!rst && !trig_clr && wr_ok) begin
            mem[wr_ptr] <= {tag, frame_pat};
        end
    end

endmodule

// File: doc/trigger_framer.md
TRIGGER_FRAMER -- requirements
Module: trigger_framer

Interface
REQ-001 SHALL have parameter FRAME_BX, default 4, meaning bunch crossings per frame (legal 2..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning frame buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter TAG_W, default 4, meaning frame tag counter width (1..8).
REQ-004 SHALL have parameter SUPPRESS_EMPTY, default 0, meaning all-zero frames are not buffered when 1.
REQ-005 SHALL have port clk160  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port bx_stb  input  1  one-cycle bunch-crossing sample strobe.
REQ-008 SHALL have port trigger  input  1  trigger level, sampled only when bx_stb=1.
REQ-009 SHALL have port trig_clr  input  1  synchronous clear.
REQ-010 SHALL have port enc_trig  output  TAG_W+FRAME_BX  head frame word {tag, pattern}.
REQ-011 SHALL have port trig_valid  output  1  buffer non-empty; enc_trig valid.
REQ-012 SHALL have port trig_ready  input  1  consumer accepts head word.
REQ-013 SHALL have port fill  output  clog2(FIFO_DEPTH)+1  buffered frame count.
REQ-014 SHALL have port overflow  output  1  sticky: a frame was dropped.

Function
REQ-015 SHALL, on each bx_stb=1 edge, shift trigger into the LSB of a FRAME_BX-bit pattern register (older samples toward MSB) and increment a bx counter modulo FRAME_BX.
REQ-016 SHALL complete a frame on the bx_stb edge where bx counter = FRAME_BX-1; frame pattern = {pattern[FRAME_BX-2:0], trigger}.
REQ-017 SHALL increment the tag counter (mod 2^TAG_W) on every completed frame, including suppressed and dropped frames.
REQ-018 SHALL write {current tag, frame pattern} into the buffer on the completing edge; trig_valid SHALL assert from the next cycle when buffer was empty.
REQ-019 SHALL, when SUPPRESS_EMPTY=1 and frame pattern is all zero, not write the frame.
REQ-020 SHALL present the oldest entry on enc_trig (show-ahead); enc_trig SHALL be 0 when empty.
REQ-021 SHALL pop the head on an edge with trig_valid=1 and trig_ready=1; trig_ready with empty buffer has no effect.
REQ-022 SHALL accept a write when fill<FIFO_DEPTH, or when fill=FIFO_DEPTH and a pop occurs on the same edge.
REQ-023 SHALL, when a write is not accepted, drop the frame, leave buffer unchanged, and set overflow=1 until trig_clr or rst.
REQ-024 SHALL update fill as +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH without gap.
REQ-026 SHALL give trig_clr priority over all activity: pattern, bx counter, tag, pointers, fill and overflow to 0 on that edge; coincident strobe, write and pop discarded.
REQ-027 SHALL ignore trigger on cycles with bx_stb=0.

Reset
REQ-028 SHALL, while rst=1, hold enc_trig=0, trig_valid=0, fill=0, overflow=0, with pattern, bx counter, tag and pointers at 0.
REQ-029 SHALL, on rst asserted mid-frame or with data buffered, discard partial frame and all entries; first frame after release starts at bx 0.

Verification
REQ-030 SHALL cover: rst pulse mid-operation -> all outputs 0 immediately, first post-reset frame carries tag 0.
REQ-031 SHALL cover: defaults, bx_stb every 4th cycle, trigger 1,0,1,1 on four strobes, trig_ready=0 -> cycle after 4th strobe edge trig_valid=1, enc_trig=8'h0B, fill=1.
REQ-032 SHALL cover: SUPPRESS_EMPTY=1, one all-zero frame then frame 0,0,0,1 -> no valid for first, then enc_trig=8'h11.
REQ-033 SHALL cover: trig_ready=0, 9 frames of 1,1,1,1 -> fill=8, overflow=1; drain yields 8'h0F,8'h1F,...,8'h7F, then trig_valid=0.
REQ-034 SHALL cover: fill=8, trig_ready=1 on same edge as frame completion -> fill stays 8, overflow stays 0, new tag at tail.
REQ-035 SHALL cover: trig_clr after 2 strobes with 3 entries buffered -> next cycle fill=0, trig_valid=0, overflow=0; following 4 strobes 1,0,0,0 give enc_trig=8'h08.
